// File: rtl/regs_wb_arbiter_if.sv
// Bus bundle between decode/writeback sources and the register-file write arbiter.
interface regs_wb_arbiter_if #(
    parameter int NSRC = 3,
    parameter int DW   = 32
);
    logic                 issue_valid;
    logic [4:0]           issue_waddr;
    logic                 issue_ready;
    logic                 flush;
    logic [NSRC-1:0]      wb_valid;
    logic [5*NSRC-1:0]    wb_waddr;
    logic [DW*NSRC-1:0]   wb_wdata;
    logic [NSRC-1:0]      wb_ready;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic [4:0]           chk_raddr1;
    logic [4:0]           chk_raddr2;
    logic [4:0]           chk_raddr3;
    logic                 chk_busy1;
    logic                 chk_busy2;
    logic                 chk_busy3;
    logic [31:0]          pending;

    modport master (
        output issue_valid, issue_waddr, flush, wb_valid, wb_waddr, wb_wdata,
               chk_raddr1, chk_raddr2, chk_raddr3,
        input  issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata,
               chk_busy1, chk_busy2, chk_busy3, pending
    );

    modport slave (
        input  issue_valid, issue_waddr, flush, wb_valid, wb_waddr, wb_wdata,
               chk_raddr1, chk_raddr2, chk_raddr3,
        output issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata,
               chk_busy1, chk_busy2, chk_busy3, pending
    );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus the
// pending-write scoreboard decode uses to stall on RAW/WAW hazards.
module regs_wb_arbiter #(
    parameter int NSRC = 3,
    parameter int DW   = 32
) (
    input logic              clk,
    input logic              rst,
    regs_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(NSRC);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [PW:0]     scan_idx;
    logic            found;
    logic [NSRC-1:0] grant;
    logic [4:0]      src_waddr [NSRC];
    logic [DW-1:0]   src_wdata [NSRC];
    logic [4:0]      sel_waddr;
    logic [DW-1:0]   sel_wdata;

    logic            rf_we_q;
    logic [4:0]      rf_waddr_q;
    logic [DW-1:0]   rf_wdata_q;

    logic [31:0]     pend;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     pend_nxt;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign src_waddr[i] = bus.wb_waddr[5*i +: 5];
        assign src_wdata[i] = bus.wb_wdata[DW*i +: DW];
    end

    // Scan from ptr upward, wrapping at NSRC; first valid source wins.
    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            scan_idx = {1'b0, ptr} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NSRC))
                scan_idx = scan_idx - (PW+1)'(NSRC);
            if (!found && bus.wb_valid[scan_idx[PW-1:0]]) begin
                found = 1'b1;
                gidx  = scan_idx[PW-1:0];
            end
        end
        grant = found ? ({{(NSRC-1){1'b0}}, 1'b1} << gidx) : '0;
    end

    assign sel_waddr   = src_waddr[gidx];
    assign sel_wdata   = src_wdata[gidx];
    assign bus.wb_ready = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= found && (sel_waddr != 5'd0);
            if (found) begin
                ptr <= (gidx == PW'(NSRC-1)) ? '0 : gidx + 1'b1;
                // x0 writebacks are consumed but leave the write port untouched
                if (sel_waddr != 5'd0) begin
                    rf_waddr_q <= sel_waddr;
                    rf_wdata_q <= sel_wdata;
                end
            end
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

    assign bus.issue_ready = ~pend[bus.issue_waddr] || (bus.issue_waddr == 5'd0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.issue_valid && bus.issue_ready && bus.issue_waddr != 5'd0)
            set_mask = 32'd1 << bus.issue_waddr;
        if (found && sel_waddr != 5'd0)
            clr_mask = 32'd1 << sel_waddr;
        // set after clear so a same-edge issue of the retiring register survives
        pend_nxt = (pend & ~clr_mask) | set_mask;
        if (bus.flush)
            pend_nxt = '0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= '0;
        else     pend <= pend_nxt;
    end

    assign bus.pending   = pend;
    assign bus.chk_busy1 = pend[bus.chk_raddr1] && (bus.chk_raddr1 != 5'd0);
    assign bus.chk_busy2 = pend[bus.chk_raddr2] && (bus.chk_raddr2 != 5'd0);
    assign bus.chk_busy3 = pend[bus.chk_raddr3] && (bus.chk_raddr3 != 5'd0);
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural model of
// the round-robin write port and pending-register set.
module tb_regs_wb_arbiter;
    localparam int NSRC = 3;
    localparam int DW   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regs_wb_arbiter_if #(.NSRC(NSRC), .DW(DW)) bus ();
    regs_wb_arbiter #(.NSRC(NSRC), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [NSRC-1:0] v;
    logic [4:0]      a [NSRC];
    logic [DW-1:0]   d [NSRC];

    always_comb begin
        bus.wb_valid = v;
        bus.wb_waddr = '0;
        bus.wb_wdata = '0;
        for (int i = 0; i < NSRC; i++) begin
            bus.wb_waddr[5*i +: 5]   = a[i];
            bus.wb_wdata[DW*i +: DW] = d[i];
        end
    end

    // reference model state
    int          m_ptr;
    bit          m_pend [32];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [DW-1:0] m_wdata;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NSRC; k++) begin
            int j;
            j = (m_ptr + k) % NSRC;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] pend_vec();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_we = 0; m_waddr = '0; m_wdata = '0;
    endtask

    // One clock: check combinational outputs, advance the model on the edge,
    // then check registered outputs. Returns the index granted (-1 if none).
    task automatic step(input string tag, output int g);
        logic [NSRC-1:0] eg;
        bit ir, clr_hit;
        int clr_a;
        #1;
        g  = exp_grant();
        eg = (g >= 0) ? NSRC'(1 << g) : '0;
        ir = !m_pend[bus.issue_waddr] || bus.issue_waddr == 0;
        chk({tag, " wb_ready"},    64'(bus.wb_ready), 64'(eg));
        chk({tag, " issue_ready"}, 64'(bus.issue_ready), 64'(ir));
        chk({tag, " busy1"}, 64'(bus.chk_busy1), 64'(m_pend[bus.chk_raddr1] && bus.chk_raddr1 != 0));
        chk({tag, " busy2"}, 64'(bus.chk_busy2), 64'(m_pend[bus.chk_raddr2] && bus.chk_raddr2 != 0));
        chk({tag, " busy3"}, 64'(bus.chk_busy3), 64'(m_pend[bus.chk_raddr3] && bus.chk_raddr3 != 0));
        @(posedge clk);
        clr_hit = 0; clr_a = 0;
        m_we = 0;
        if (g >= 0) begin
            m_ptr = (g + 1) % NSRC;
            if (a[g] != 0) begin
                m_we = 1; m_waddr = a[g]; m_wdata = d[g];
                clr_hit = 1; clr_a = a[g];
            end
        end
        if (clr_hit) m_pend[clr_a] = 0;
        if (bus.issue_valid && ir && bus.issue_waddr != 0) m_pend[bus.issue_waddr] = 1;
        if (bus.flush) for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_pend[0] = 0;
        #1;
        chk({tag, " rf_we"},    64'(bus.rf_we), 64'(m_we));
        chk({tag, " rf_waddr"}, 64'(bus.rf_waddr), 64'(m_waddr));
        chk({tag, " rf_wdata"}, 64'(bus.rf_wdata), 64'(m_wdata));
        chk({tag, " pending"},  64'(bus.pending), 64'(pend_vec()));
    endtask

    task automatic idle_inputs();
        v = '0;
        for (int i = 0; i < NSRC; i++) begin a[i] = '0; d[i] = '0; end
        bus.issue_valid = 0; bus.issue_waddr = '0; bus.flush = 0;
        bus.chk_raddr1 = '0; bus.chk_raddr2 = '0; bus.chk_raddr3 = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    int g;

    initial begin
        idle_inputs();
        rst = 1;
        #2;
        chk("reset rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset pending", 64'(bus.pending), 64'd0);
        do_reset();

        // mid-cycle async reset with a write in flight
        bus.issue_valid = 1; bus.issue_waddr = 5'd4;
        v = 3'b111;
        for (int i = 0; i < NSRC; i++) begin a[i] = 5'(i + 1); d[i] = 32'hA000_0000 + i; end
        step("pre_rst", g);
        bus.issue_valid = 0;
        #2 rst = 1;
        #1;
        chk("midrst rf_we", 64'(bus.rf_we), 64'd0);
        chk("midrst pending", 64'(bus.pending), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        step("post_rst", g);
        chk("post_rst first grant", 64'(g), 64'd0);

        // round robin, all three held valid
        do_reset();
        v = 3'b111;
        for (int i = 0; i < NSRC; i++) begin a[i] = 5'(10 + i); d[i] = 32'hB000_0000 + i; end
        for (int k = 0; k < 6; k++) begin
            step("rr", g);
            chk("rr order", 64'(g), 64'(k % 3));
            chk("rr rf_waddr", 64'(bus.rf_waddr), 64'(10 + k % 3));
        end

        // scoreboard: issue x5, LSU retires it
        do_reset();
        idle_inputs();
        bus.issue_valid = 1; bus.issue_waddr = 5'd5;
        step("sb issue", g);
        bus.issue_valid = 0; bus.chk_raddr1 = 5'd5;
        step("sb wait1", g);
        chk("sb busy1 set", 64'(bus.chk_busy1), 64'd1);
        step("sb wait2", g);
        v = 3'b010; a[1] = 5'd5; d[1] = 32'hDEADBEEF;
        step("sb wb", g);
        v = '0;
        chk("sb busy1 clear", 64'(bus.chk_busy1), 64'd0);
        chk("sb rf_we", 64'(bus.rf_we), 64'd1);
        chk("sb rf_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("sb rf_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);

        // WAW block on x7
        bus.issue_valid = 1; bus.issue_waddr = 5'd7;
        step("waw issue", g);
        #1 chk("waw blocked", 64'(bus.issue_ready), 64'd0);
        step("waw retry", g);
        chk("waw pend7", 64'(bus.pending[7]), 64'd1);
        bus.issue_valid = 0;
        v = 3'b001; a[0] = 5'd7; d[0] = 32'h7777;
        step("waw wb", g);
        v = '0;
        chk("waw ready again", 64'(bus.issue_ready), 64'd1);

        // x0 writeback, then same-edge set/clear of x9
        v = 3'b100; a[2] = 5'd0; d[2] = 32'h1234;
        step("x0 wb", g);
        chk("x0 grant", 64'(g), 64'd2);
        chk("x0 rf_we", 64'(bus.rf_we), 64'd0);
        v = 3'b100; a[2] = 5'd9; d[2] = 32'h9999;
        bus.issue_valid = 1; bus.issue_waddr = 5'd9;
        step("x9 same", g);
        v = '0; bus.issue_valid = 0;
        chk("x9 set wins", 64'(bus.pending[9]), 64'd1);

        // flush with a same-cycle issue and an in-flight write
        do_reset();
        idle_inputs();
        for (int r = 8; r < 12; r++) begin
            bus.issue_valid = 1; bus.issue_waddr = 5'(r);
            step("fl fill", g);
        end
        chk("fl pending", 64'(bus.pending), 64'h0F00);
        bus.issue_waddr = 5'd3; bus.flush = 1;
        v = 3'b001; a[0] = 5'd20; d[0] = 32'hF00D;
        step("fl edge", g);
        chk("fl cleared", 64'(bus.pending), 64'd0);
        chk("fl rf_we", 64'(bus.rf_we), 64'd1);
        chk("fl rf_waddr", 64'(bus.rf_waddr), 64'd20);
        idle_inputs();

        // randomized traffic; sources hold requests until granted
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NSRC; i++)
                if (!v[i] && $urandom_range(1, 0) == 1) begin
                    v[i] = 1;
                    a[i] = 5'($urandom_range(11, 0));
                    d[i] = $urandom;
                end
            bus.issue_valid = ($urandom_range(2, 0) != 0);
            bus.issue_waddr = 5'($urandom_range(11, 0));
            bus.flush       = ($urandom_range(15, 0) == 0);
            bus.chk_raddr1  = 5'($urandom_range(11, 0));
            bus.chk_raddr2  = 5'($urandom_range(31, 0));
            bus.chk_raddr3  = 5'($urandom_range(11, 0));
            step("rnd", g);
            if (g >= 0) v[g] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
